// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared note constants, one-hot codes and period helpers
//
// Purpose: note frequencies C4..C5, the one-hot note codes shared with the
// DIP-switch tone generator, the detector state type and elaboration-time
// helpers for computing nominal tone periods.
// Ports: none (package).
package note_pkg;

    localparam int NUM_NOTES = 8;

    // Note frequencies in Hz, C4 up to C5
    localparam int unsigned FREQ_C4 = 261;
    localparam int unsigned FREQ_D4 = 293;
    localparam int unsigned FREQ_E4 = 329;
    localparam int unsigned FREQ_F4 = 349;
    localparam int unsigned FREQ_G4 = 392;
    localparam int unsigned FREQ_A4 = 440;
    localparam int unsigned FREQ_B4 = 493;
    localparam int unsigned FREQ_C5 = 523;

    // One-hot codes, identical to the generator's DIP-switch encoding
    localparam logic [7:0] NOTE_NONE = 8'b0000_0000;
    localparam logic [7:0] NOTE_C4   = 8'b0000_0001;
    localparam logic [7:0] NOTE_D4   = 8'b0000_0010;
    localparam logic [7:0] NOTE_E4   = 8'b0000_0100;
    localparam logic [7:0] NOTE_F4   = 8'b0000_1000;
    localparam logic [7:0] NOTE_G4   = 8'b0001_0000;
    localparam logic [7:0] NOTE_A4   = 8'b0010_0000;
    localparam logic [7:0] NOTE_B4   = 8'b0100_0000;
    localparam logic [7:0] NOTE_C5   = 8'b1000_0000;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meas_state_t;

    function automatic int unsigned note_freq(input int idx);
        case (idx)
            0:       return FREQ_C4;
            1:       return FREQ_D4;
            2:       return FREQ_E4;
            3:       return FREQ_F4;
            4:       return FREQ_G4;
            5:       return FREQ_A4;
            6:       return FREQ_B4;
            default: return FREQ_C5;
        endcase
    endfunction

    function automatic logic [7:0] note_code(input int idx);
        case (idx)
            0:       return NOTE_C4;
            1:       return NOTE_D4;
            2:       return NOTE_E4;
            3:       return NOTE_F4;
            4:       return NOTE_G4;
            5:       return NOTE_A4;
            6:       return NOTE_B4;
            default: return NOTE_C5;
        endcase
    endfunction

    // Tone period in system clocks, truncated; only used at elaboration
    function automatic int unsigned nominal_period(input int unsigned sys_clk,
                                                   input int unsigned freq);
        return sys_clk / freq;
    endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// rtl/tone_sync_edge.sv - 2-FF synchronizer with registered rising-edge pulse
//
// Purpose: brings the asynchronous tone input into the clk domain and emits a
// one-cycle pulse per rising edge, three clocks after the pad edge.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   tone_in in  asynchronous square wave
//   rise    out one-cycle rising-edge pulse
module tone_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic tone_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= tone_in;
            sync2 <= sync1;
            prev  <= sync2;
            rise  <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/note_detector.sv
// rtl/note_detector.sv - tone period measurement and C4..C5 note classification
//
// Purpose: measures the clk-cycle period between rising edges of tone_in,
// classifies it against per-note tolerance windows and reports a confirmed
// note as a one-hot code.
// Ports:
//   clk         in  system clock
//   rst         in  asynchronous active-high reset
//   tone_in     in  asynchronous square-wave input
//   note_onehot out detected note (bit0=C4 .. bit7=C5), 0 = none
//   note_valid  out note_onehot is nonzero
//   note_change out one-cycle pulse when note_onehot changes
//   period      out last measured period in clk cycles
module note_detector
    import note_pkg::*;
#(
    parameter int SYS_CLK   = 100000000,
    parameter int CNT_W     = 20,
    parameter int TOL_SHIFT = 6,
    parameter int CONFIRM   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output logic [7:0]       note_onehot,
    output logic             note_valid,
    output logic             note_change,
    output logic [CNT_W-1:0] period
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               MW      = $clog2(CONFIRM + 1);
    localparam logic [MW-1:0]    CONF_M  = MW'(CONFIRM);

    logic rise;

    tone_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .tone_in (tone_in),
        .rise    (rise)
    );

    meas_state_t      state;
    meas_state_t      state_next;
    logic [CNT_W-1:0] count;
    logic             saturated;
    logic             cnt_start;
    logic             cnt_inc;
    logic             latch;
    logic             sat_clear;
    logic             period_upd;

    // A stopped or sub-audible tone lets the counter run to all ones
    assign saturated = (state == ST_MEASURE) && (count == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (rise)      state_next = ST_MEASURE;
            ST_MEASURE: if (saturated) state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // Saturation outranks a coincident rise
    always_comb begin
        cnt_start = 1'b0;
        cnt_inc   = 1'b0;
        latch     = 1'b0;
        sat_clear = 1'b0;
        case (state)
            ST_IDLE: cnt_start = rise;
            ST_MEASURE: begin
                if (saturated) begin
                    sat_clear = 1'b1;
                end else if (rise) begin
                    latch = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // count restarts at 1 so that a latched value is the exact edge spacing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (sat_clear) begin
            count <= '0;
        end else if (cnt_start || latch) begin
            count <= CNT_W'(1);
        end else if (cnt_inc) begin
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period     <= '0;
            period_upd <= 1'b0;
        end else begin
            period_upd <= latch;
            if (latch) begin
                period <= count;
            end
        end
    end

    // Tolerance windows, fixed at elaboration
    logic [NUM_NOTES-1:0] class_hit;

    for (genvar i = 0; i < NUM_NOTES; i++) begin : g_win
        localparam int unsigned      NOM = nominal_period(SYS_CLK, note_freq(i));
        localparam logic [CNT_W-1:0] LO  = CNT_W'(NOM - (NOM >> TOL_SHIFT));
        localparam logic [CNT_W-1:0] HI  = CNT_W'(NOM + (NOM >> TOL_SHIFT));
        assign class_hit[i] = (period >= LO) && (period <= HI);
    end

    logic [7:0] note_class;

    always_comb begin
        note_class = NOTE_NONE;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (class_hit[i]) begin
                note_class = note_class | note_code(i);
            end
        end
    end

    // Confirmation: CONFIRM identical classes in a row, "none" included
    logic [7:0]    candidate;
    logic [MW-1:0] match_cnt;
    logic [7:0]    cand_next;
    logic [MW-1:0] match_next;
    logic          take;

    always_comb begin
        cand_next  = candidate;
        match_next = match_cnt;
        if (note_class == candidate) begin
            if (match_cnt != CONF_M) begin
                match_next = match_cnt + MW'(1);
            end
        end else begin
            cand_next  = note_class;
            match_next = MW'(1);
        end
    end

    assign take = (match_next == CONF_M) && (cand_next != note_onehot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            candidate   <= NOTE_NONE;
            match_cnt   <= '0;
            note_onehot <= NOTE_NONE;
            note_change <= 1'b0;
        end else if (sat_clear) begin
            candidate   <= NOTE_NONE;
            match_cnt   <= '0;
            note_onehot <= NOTE_NONE;
            note_change <= |note_onehot;
        end else if (period_upd) begin
            candidate   <= cand_next;
            match_cnt   <= match_next;
            note_change <= take;
            if (take) begin
                note_onehot <= cand_next;
            end
        end else begin
            note_change <= 1'b0;
        end
    end

    assign note_valid = |note_onehot;

endmodule

// File: doc/note_detector.md
Name: note_detector

Overview:
- Receive-side counterpart of the DIP-switch tone generator.
- Measures the period of an external square-wave tone on `tone_in` and identifies which of the eight notes C4..C5 it is.
- Reports the note as a one-hot code identical to the generator's DIP-switch encoding.
- Used for loopback self-test of the speaker path and for driving LEDs from an external tone source.

Parameters:
- SYS_CLK, 100000000, system clock frequency in Hz.
- CNT_W, 20, width of the period counter and of `period`.
- TOL_SHIFT, 6, match window is nominal ± (nominal >> TOL_SHIFT), about ±1.56%.
- CONFIRM, 2, consecutive identical classifications required before `note_onehot` changes.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- tone_in  in  1  asynchronous square-wave input.
- note_onehot  out  8  detected note. Bit0=C4, bit1=D4, bit2=E4, bit3=F4, bit4=G4, bit5=A4, bit6=B4, bit7=C5. 0 means none.
- note_valid  out  1  high when `note_onehot` is nonzero.
- note_change  out  1  one-cycle pulse when `note_onehot` changes value.
- period  out  CNT_W  last measured period in clk cycles.

Behaviour:
- Reset (async, active-high):
  - Outputs: `note_onehot`=0, `note_valid`=0, `note_change`=0, `period`=0.
  - Internal: sync flops=0, `count`=0, candidate=0, `match_cnt`=0, state=IDLE.
  - Reset mid-measurement discards the partial period; first edge after release starts a fresh measurement.
- Input conditioning:
  - `tone_in` passes through a 2-FF synchronizer, then a rising-edge detector (registered previous sample).
  - `rise` pulses one cycle per rising edge, 3 clk after the pad edge.
- State machine:
  - IDLE: `count` held at 0. On `rise`: `count`<=1, go to MEASURE. No period is latched.
  - MEASURE: `count` increments each cycle.
    - On `rise`: `period`<=`count` (exact cycles between edges), `count`<=1.
    - On `count` reaching 2^CNT_W-1 (about 10.5 ms, tone below ~95 Hz or stopped): go to IDLE. Also force `note_onehot`=0, `match_cnt`=0, candidate=0. Pulse `note_change` if `note_onehot` was nonzero.
    - `rise` and saturation in the same cycle: saturation wins.
- Classification: combinational from `period`.
  - Nominal periods are SYS_CLK/f with integer truncation. At defaults:
    - C4 383141, D4 341296, E4 303951, F4 286532
    - G4 255102, A4 227272, B4 202839, C5 191204
  - Match when nom-(nom>>TOL_SHIFT) ≤ period ≤ nom+(nom>>TOL_SHIFT), bounds inclusive.
  - Windows are disjoint at defaults. No match gives class 0.
- Confirmation: evaluated in the cycle after `period` updates.
  - If class == candidate: `match_cnt` increments, saturating at CONFIRM.
  - Otherwise: candidate<=class, `match_cnt`<=1.
  - When `match_cnt` reaches CONFIRM and candidate != `note_onehot`: `note_onehot`<=candidate, with a `note_change` pulse on the same cycle.
  - A "none" class therefore also needs CONFIRM consecutive periods to clear the output.
- Latency: `note_onehot` updates 2 clk after the `rise` that completes the CONFIRM-th matching period.
- Widths: all comparisons unsigned at CNT_W. Bounds are computed at elaboration; there is no runtime division.

Decomposition:
- Package `note_pkg`:
  - Note frequency constants C4..C5 (261, 293, 329, 349, 392, 440, 493, 523).
  - One-hot note codes, shared with the generator.
  - Constant function `nominal_period(sys_clk, freq)`.
- Sub-module `tone_sync_edge`: 2-FF synchronizer plus rising-edge pulse, async active-high reset.

Test Plan:
- Reset, then `tone_in` held 0 → all outputs 0, state stays IDLE, no `note_change`.
- Square wave with period 227272 cycles (A4), 4 periods:
  - `period`=227272 after 2nd edge.
  - `note_onehot`=8'b00100000 and `note_change` pulse 2 clk after the 3rd edge.
  - `note_valid`=1.
- Lock on C4 (383141), then switch to C5 (191204):
  - First C5 period alone does not change output.
  - After 2nd C5 period, `note_onehot`=8'b10000000 with one `note_change` pulse.
- Window boundaries on E4: periods 299202 and 308700 → E4 detected. Periods 299201 and 308701 → class 0, output clears after 2 such periods.
- Lock on G4, then stop `tone_in` → at `count`=1048575, `note_onehot`=0, `note_valid`=0, one `note_change` pulse, state IDLE.
- Assert `rst` mid-period while locked on D4 → outputs 0 immediately. After release, two D4 periods are needed before the first `period` latch and lock.
